// File: rtl/stove_heater_driver.sv
// stove_heater_driver: slow-PWM relay drive for one burner.
// Level is latched only at period starts, so the relay sees whole slots.
module stove_heater_driver #(
  parameter int LEVELS     = 9,
  parameter int STEP_TICKS = 1000
) (
  input  logic       clk,
  input  logic       async_nreset,
  input  logic       enable,
  input  logic [3:0] level_in,
  output logic       heater_out,
  output logic [3:0] level_active,
  output logic       period_strobe
);
  localparam int TW = $clog2(STEP_TICKS);
  localparam int SW = LEVELS > 1 ? $clog2(LEVELS) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HEAT = 2'd1;
  localparam logic [1:0] REST = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [3:0]    level_q, level_d;
  logic          heater_q, heater_d;
  logic          strobe_q, strobe_d;
  logic          tick_wrap, period_end, start;
  logic [3:0]    lvl, slot_inc;

  always_comb begin
    lvl        = level_in > 4'(LEVELS) ? 4'(LEVELS) : level_in;
    tick_wrap  = tick_q == TW'(STEP_TICKS - 1);
    period_end = tick_wrap && slot_q == SW'(LEVELS - 1);
    slot_inc   = 4'(slot_q) + 4'd1;
    start      = enable && (state_q == IDLE || period_end);
    state_d    = IDLE;
    tick_d     = '0;
    slot_d     = '0;
    level_d    = '0;
    strobe_d   = 1'b0;
    if (start) begin
      level_d  = lvl;
      state_d  = lvl != 4'd0 ? HEAT : REST;
      strobe_d = 1'b1;
    end else if (enable) begin
      level_d = level_q;
      tick_d  = tick_wrap ? '0 : tick_q + TW'(1);
      slot_d  = tick_wrap ? slot_q + SW'(1) : slot_q;
      // heating ends once level_active whole slots have elapsed
      state_d = (state_q == HEAT && tick_wrap && slot_inc == level_q) ? REST : state_q;
    end
    heater_d = state_d == HEAT;
  end

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      slot_q   <= '0;
      level_q  <= '0;
      heater_q <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      slot_q   <= slot_d;
      level_q  <= level_d;
      heater_q <= heater_d;
      strobe_q <= strobe_d;
    end
  end

  assign heater_out    = heater_q;
  assign level_active  = level_q;
  assign period_strobe = strobe_q;
endmodule

// File: tb/tb_stove_heater_driver.sv
// tb_stove_heater_driver: directed tests with LEVELS=9, STEP_TICKS=4 (36-cycle period).
module tb_stove_heater_driver;
  logic       clk = 1'b0;
  logic       async_nreset = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] level_in = 4'd0;
  logic       heater_out;
  logic [3:0] level_active;
  logic       period_strobe;
  int passed = 0;
  int total = 0;
  int h, s;

  stove_heater_driver #(.LEVELS(9), .STEP_TICKS(4)) dut (
    .clk(clk),
    .async_nreset(async_nreset),
    .enable(enable),
    .level_in(level_in),
    .heater_out(heater_out),
    .level_active(level_active),
    .period_strobe(period_strobe)
  );

  always #5 clk = ~clk;

  // samples n consecutive cycles at the falling edge
  task automatic run_window(input int n, output int highs, output int strobes);
    highs = 0;
    strobes = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      highs += int'(heater_out);
      strobes += int'(period_strobe);
    end
  endtask

  task automatic go_idle();
    enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    async_nreset = 1'b0;
    repeat (2) @(negedge clk);
    async_nreset = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    level_in = 4'd5;
    @(negedge clk);
    total++; if (heater_out !== 1'b1 || level_active !== 4'd5 || period_strobe !== 1'b1)
      $display("FAIL reset_prestart: got h=%0b l=%0d s=%0b expected h=1 l=5 s=1", heater_out, level_active, period_strobe); else passed++;
    @(posedge clk);
    #3 async_nreset = 1'b0;
    #1;
    total++; if (heater_out !== 1'b0 || level_active !== 4'd0 || period_strobe !== 1'b0)
      $display("FAIL reset_async: got h=%0b l=%0d s=%0b expected all 0", heater_out, level_active, period_strobe); else passed++;
    repeat (2) @(negedge clk);
    total++; if (heater_out !== 1'b0 || level_active !== 4'd0 || period_strobe !== 1'b0)
      $display("FAIL reset_held: got h=%0b l=%0d s=%0b expected all 0", heater_out, level_active, period_strobe); else passed++;
    async_nreset = 1'b1;
    #2;
    total++; if (heater_out !== 1'b0 || level_active !== 4'd0)
      $display("FAIL reset_release: got h=%0b l=%0d expected h=0 l=0", heater_out, level_active); else passed++;
    @(negedge clk);
    total++; if (heater_out !== 1'b1 || level_active !== 4'd5 || period_strobe !== 1'b1)
      $display("FAIL reset_restart: got h=%0b l=%0d s=%0b expected h=1 l=5 s=1", heater_out, level_active, period_strobe); else passed++;
    go_idle();
    total++; if (heater_out !== 1'b0 || level_active !== 4'd0)
      $display("FAIL reset_idle: got h=%0b l=%0d expected h=0 l=0", heater_out, level_active); else passed++;
  endtask

  task automatic test_periodic();
    enable = 1'b1;
    level_in = 4'd3;
    run_window(12, h, s);
    total++; if (h !== 12 || s !== 1) $display("FAIL lvl3_heat: got highs=%0d strobes=%0d expected 12 1", h, s); else passed++;
    total++; if (level_active !== 4'd3) $display("FAIL lvl3_active: got %0d expected 3", level_active); else passed++;
    run_window(24, h, s);
    total++; if (h !== 0 || s !== 0) $display("FAIL lvl3_rest: got highs=%0d strobes=%0d expected 0 0", h, s); else passed++;
    run_window(1, h, s);
    total++; if (h !== 1 || s !== 1) $display("FAIL lvl3_restart: got highs=%0d strobes=%0d expected 1 1", h, s); else passed++;
    run_window(35, h, s);
    total++; if (h !== 11 || s !== 0) $display("FAIL lvl3_period2: got highs=%0d strobes=%0d expected 11 0", h, s); else passed++;
    go_idle();
  endtask

  task automatic test_level_extremes();
    enable = 1'b1;
    level_in = 4'd0;
    run_window(36, h, s);
    total++; if (h !== 0 || s !== 1) $display("FAIL lvl0_p1: got highs=%0d strobes=%0d expected 0 1", h, s); else passed++;
    run_window(36, h, s);
    total++; if (h !== 0 || s !== 1) $display("FAIL lvl0_p2: got highs=%0d strobes=%0d expected 0 1", h, s); else passed++;
    level_in = 4'd9;
    run_window(108, h, s);
    total++; if (h !== 108 || s !== 3) $display("FAIL lvl9_3periods: got highs=%0d strobes=%0d expected 108 3", h, s); else passed++;
    total++; if (level_active !== 4'd9) $display("FAIL lvl9_active: got %0d expected 9", level_active); else passed++;
    go_idle();
  endtask

  task automatic test_mid_change();
    enable = 1'b1;
    level_in = 4'd3;
    run_window(10, h, s);
    total++; if (h !== 10 || s !== 1) $display("FAIL chg_start: got highs=%0d strobes=%0d expected 10 1", h, s); else passed++;
    level_in = 4'd6;
    run_window(26, h, s);
    total++; if (h !== 2 || s !== 0) $display("FAIL chg_ignored: got highs=%0d strobes=%0d expected 2 0", h, s); else passed++;
    run_window(1, h, s);
    total++; if (level_active !== 4'd6 || s !== 1) $display("FAIL chg_latched: got level=%0d strobes=%0d expected 6 1", level_active, s); else passed++;
    run_window(35, h, s);
    total++; if (h !== 23) $display("FAIL chg_heat6: got highs=%0d expected 23", h); else passed++;
    go_idle();
  endtask

  task automatic test_safety();
    enable = 1'b1;
    level_in = 4'd4;
    run_window(5, h, s);
    total++; if (h !== 5 || s !== 1) $display("FAIL safe_heat: got highs=%0d strobes=%0d expected 5 1", h, s); else passed++;
    enable = 1'b0;
    run_window(1, h, s);
    total++; if (heater_out !== 1'b0 || level_active !== 4'd0 || s !== 0)
      $display("FAIL safe_off: got h=%0b l=%0d strobes=%0d expected 0 0 0", heater_out, level_active, s); else passed++;
    run_window(6, h, s);
    total++; if (h !== 0 || s !== 0) $display("FAIL safe_idle: got highs=%0d strobes=%0d expected 0 0", h, s); else passed++;
    enable = 1'b1;
    run_window(16, h, s);
    total++; if (h !== 16 || s !== 1) $display("FAIL safe_reheat: got highs=%0d strobes=%0d expected 16 1", h, s); else passed++;
    run_window(1, h, s);
    total++; if (h !== 0 || level_active !== 4'd4) $display("FAIL safe_rest: got h=%0d l=%0d expected 0 4", h, level_active); else passed++;
    go_idle();
  endtask

  task automatic test_clamp();
    enable = 1'b1;
    level_in = 4'd15;
    run_window(1, h, s);
    total++; if (level_active !== 4'd9 || s !== 1) $display("FAIL clamp15: got level=%0d strobes=%0d expected 9 1", level_active, s); else passed++;
    run_window(35, h, s);
    total++; if (h !== 35) $display("FAIL clamp15_heat: got highs=%0d expected 35", h); else passed++;
    level_in = 4'd10;
    run_window(36, h, s);
    total++; if (h !== 36 || s !== 1 || level_active !== 4'd9)
      $display("FAIL clamp10: got highs=%0d strobes=%0d level=%0d expected 36 1 9", h, s, level_active); else passed++;
    go_idle();
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_level_extremes();
    test_mid_change();
    test_safety();
    test_clamp();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
